// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin arbiter sharing one 8N1 UART TX line among NREQ byte requesters
// One byte per frame; divider and data are latched at acceptance, line idles high between frames.
module uart_tx_sched #(
  parameter int NREQ  = 4,
  parameter int DIV_W = 16,
  parameter int GID_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic [DIV_W-1:0]  baud_div,
  output logic              tx,
  output logic              busy,
  output logic [GID_W-1:0]  grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state;
  logic [7:0]       shreg;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [2:0]       idx;
  logic [GID_W-1:0] rr_ptr;

  logic             found;
  logic [GID_W-1:0] winner;
  logic [GID_W-1:0] winner_next;
  logic [GID_W:0]   cand;
  logic [GID_W:0]   cand_next;
  logic [DIV_W-1:0] d_eff;
  logic [7:0]       win_data;

  // Cyclic search starting at rr_ptr; the extra bit of cand absorbs the wrap.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + (GID_W+1)'(i);
      if (cand >= (GID_W+1)'(NREQ))
        cand = cand - (GID_W+1)'(NREQ);
      if (!found && req_valid[cand[GID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[GID_W-1:0];
      end
    end
  end

  always_comb begin
    cand_next = {1'b0, winner} + (GID_W+1)'(1);
    if (cand_next >= (GID_W+1)'(NREQ))
      cand_next = '0;
    winner_next = cand_next[GID_W-1:0];
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == S_IDLE && found)
      req_ready[winner] = 1'b1;
  end

  assign win_data = req_data[{winner, 3'b000} +: 8];
  assign d_eff    = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
      shreg    <= '0;
      div_q    <= '0;
      cnt      <= '0;
      idx      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            shreg    <= win_data;
            div_q    <= d_eff;
            cnt      <= d_eff - DIV_W'(1);
            grant_id <= winner;
            rr_ptr   <= winner_next;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            cnt   <= div_q - DIV_W'(1);
            idx   <= 3'd0;
            tx    <= shreg[0];
            state <= S_DATA;
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            cnt <= div_q - DIV_W'(1);
            if (idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              idx <= idx + 3'd1;
              tx  <= shreg[idx + 3'd1];
            end
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        S_STOP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one 8N1 UART transmit line among up to `NREQ` byte-stream requesters (boot monitor, debug console, test-status reporter, etc.). It sits between the requesters and the GPIO-mapped UART TX pin of the `e203_soc_demo` platform. It contains the arbiter, a per-frame baud-divider latch and the serializer state machine. It accepts one byte per frame and holds the line idle-high between frames.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `DIV_W`, default 16: width of the baud divider.
- `GID_W`, default 2: width of `grant_id`, equal to clog2(NREQ).

- `clk` in 1: single system clock. The bench uses 27 MHz.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `req_valid` in NREQ: requester i has a byte pending.
- `req_data` in NREQ*8: byte of requester i is at bits [8i+7:8i].
- `req_ready` out NREQ: one-hot accept strobe. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `baud_div` in DIV_W: clock cycles per bit (D). Values below 2 are treated as 2.
- `tx` out 1: serial output, idle high.
- `busy` out 1: high while a frame is on the line.
- `grant_id` out GID_W: index of the requester whose frame is in flight or was last sent.

## Operation
- **States:** IDLE, START, DATA, STOP.
- **IDLE**
  - `tx`=1 and `busy`=0.
  - If any `req_valid` is high, the winner is the first valid index searched cyclically from `rr_ptr`.
  - `req_ready[winner]`=1 combinationally, in the same cycle. All other `req_ready` bits are 0.
  - On the clock edge: latch `req_data[winner]` into the shift register, latch the effective D, set `grant_id`=winner, set `rr_ptr`=(winner+1) mod NREQ, and go to START.
- **START:** `tx`=0 for D cycles, then go to DATA with bit index 0.
- **DATA:** `tx` = shift register bit[idx], LSB first, for D cycles per bit. After idx 7 completes, go to STOP.
- **STOP:** `tx`=1 for D cycles, then go to IDLE.
- `req_ready` is 0 in every state other than IDLE. There is no queueing inside the block.
- A requester holds `req_valid` and `req_data` stable until accepted. Dropping `req_valid` before acceptance withdraws the request without side effects.
- Changes to `baud_div` mid-frame have no effect; D is latched at acceptance.
- Bit-period counter: DIV_W bits, counts D-1 down to 0, reloads on each bit boundary.
- A request arriving during START/DATA/STOP waits; it is arbitrated in the next IDLE cycle.
- Several requests in the same IDLE cycle: exactly one `req_ready` bit is set, chosen by the round-robin rule.

## Timing
- **Reset values:**
  - `tx`=1, `busy`=0, `grant_id`=0, `req_ready`=0 while `rst_n` is low.
  - `rr_ptr`=0, so requester 0 has first priority.
  - State is IDLE and all counters are 0.
- **Latency:** `req_valid` high in IDLE leads to `req_ready` in the same cycle. `tx` falls on the next edge.
- **Frame length:** 10*D cycles with `busy`=1, then at least 1 IDLE cycle. Back-to-back throughput is one byte per 10*D+1 cycles.
- `busy` rises on the edge leaving IDLE and falls on the edge entering IDLE.
- **Reset asserted mid-frame:** `tx` goes high asynchronously and the in-flight byte is dropped, with no further handshake. After `rst_n` rises, arbitration restarts with requester 0 first.
- All outputs except `req_ready` are registered. `req_ready` is combinational from `req_valid`, the state and `rr_ptr`.

## Test plan
- **Single byte:** req0 sends 0x41 with D=234.
  - `req_ready[0]` pulses for exactly 1 cycle.
  - `tx` shows 234 low cycles, then bits 1,0,0,0,0,0,1,0, then 234 high cycles.
  - `busy` is high for 2340 cycles.
- **All requesters valid:** all four hold valid continuously with bytes 0x10..0x13, D=4.
  - Grant order is 0,1,2,3,0.
  - Frames start 41 cycles apart.
- **Round-robin resume:** after a grant to req2, req1 and req3 assert together.
  - req3 is granted first, then req1.
- **Divider clamp and latch:**
  - `baud_div`=0 gives a 20-cycle frame.
  - Changing `baud_div` from 8 to 16 mid-frame leaves the current frame at 80 cycles; the next frame is 160 cycles.
- **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3.
  - `tx`=1 and `busy`=0 without waiting for a clock edge.
  - After release with req1 and req0 both valid, req0 is granted first.
- **Withdrawn request:** req2 raises valid during req0's frame and drops it before STOP ends.
  - No `req_ready[2]` pulse occurs.
  - The line stays idle.
